// File: rtl/matrix_tile_merge8_if.sv
`default_nettype none
// ============================================================================
//  matrix_tile_merge8_if
//  Tile-input and matrix-output handshake bundle for matrix_tile_merge8.
//  Revision: 1.0
// ============================================================================
interface matrix_tile_merge8_if #(
    parameter int WIDTH = 16
);
    logic                                in_valid;
    logic                                in_ready;
    logic [1:0]                          tile_idx;
    logic [3:0][3:0][2*WIDTH-1:0]        tile_in;
    logic [4:0]                          m_bit1;
    logic [4:0]                          m_bit2;
    logic                                flag;

    logic                                out_valid;
    logic                                out_ready;
    logic [7:0][7:0][2*WIDTH-1:0]        C;
    logic [4:0]                          out_m_bit1;
    logic [4:0]                          out_m_bit2;
    logic                                out_flag;
    logic                                dup_err;
    logic                                fmt_err;
    logic [3:0]                          tile_mask;

    // master: tile producer and matrix consumer
    modport master (
        output in_valid, tile_idx, tile_in, m_bit1, m_bit2, flag, out_ready,
        input  in_ready, out_valid, C, out_m_bit1, out_m_bit2, out_flag,
               dup_err, fmt_err, tile_mask
    );

    // slave: the merge block itself
    modport slave (
        input  in_valid, tile_idx, tile_in, m_bit1, m_bit2, flag, out_ready,
        output in_ready, out_valid, C, out_m_bit1, out_m_bit2, out_flag,
               dup_err, fmt_err, tile_mask
    );
endinterface
`default_nettype wire

// File: rtl/matrix_tile_merge8.sv
`default_nettype none
// ============================================================================
//  matrix_tile_merge8
//  Reassembles an 8x8 matrix from four tagged 4x4 tiles and presents it on a
//  valid/ready handshake, with format latching and duplicate/format checks.
//  Revision: 1.0
// ============================================================================
module matrix_tile_merge8 #(
    parameter int WIDTH = 16
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              clr,
    matrix_tile_merge8_if.slave    bus
);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    state_t                        r_state;
    state_t                        w_state_next;

    logic [3:0]                    r_tile_mask;
    logic                          r_dup_err;
    logic                          r_fmt_err;
    logic [4:0]                    r_m_bit1;
    logic [4:0]                    r_m_bit2;
    logic                          r_flag;
    logic [7:0][7:0][2*WIDTH-1:0]  r_c;

    logic                          w_accept;
    logic                          w_release;
    logic [3:0]                    w_mask_set;
    logic                          w_first;
    logic                          w_dup;
    logic                          w_fmt_diff;

    assign w_accept   = bus.in_valid && (r_state == COLLECT) && !clr;
    assign w_release  = (r_state == FULL) && bus.out_ready && !clr;
    assign w_mask_set = 4'b0001 << bus.tile_idx;
    assign w_first    = (r_tile_mask == 4'b0000);
    assign w_dup      = |(r_tile_mask & w_mask_set);
    assign w_fmt_diff = (bus.m_bit1 != r_m_bit1) || (bus.m_bit2 != r_m_bit2) ||
                        (bus.flag != r_flag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (clr) begin
            w_state_next = COLLECT;
        end else begin
            case (r_state)
                COLLECT: begin
                    if (w_accept && ((r_tile_mask | w_mask_set) == 4'b1111)) begin
                        w_state_next = FULL;
                    end
                end
                FULL: begin
                    if (bus.out_ready) begin
                        w_state_next = COLLECT;
                    end
                end
                default: w_state_next = COLLECT;
            endcase
        end
    end

    // Tracking and format fields; the format is relatched by the first tile of each matrix.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tile_mask <= 4'b0000;
            r_dup_err   <= 1'b0;
            r_fmt_err   <= 1'b0;
            r_m_bit1    <= 5'd0;
            r_m_bit2    <= 5'd0;
            r_flag      <= 1'b0;
        end else if (clr || w_release) begin
            r_tile_mask <= 4'b0000;
            r_dup_err   <= 1'b0;
            r_fmt_err   <= 1'b0;
        end else if (w_accept) begin
            r_tile_mask <= r_tile_mask | w_mask_set;
            r_dup_err   <= r_dup_err | w_dup;
            if (w_first) begin
                r_m_bit1 <= bus.m_bit1;
                r_m_bit2 <= bus.m_bit2;
                r_flag   <= bus.flag;
            end else begin
                r_fmt_err <= r_fmt_err | w_fmt_diff;
            end
        end
    end

    // Matrix storage is only ever overwritten, never flushed, except by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c <= '0;
        end else if (w_accept) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    r_c[{bus.tile_idx[1], 2'(r)}][{bus.tile_idx[0], 2'(c)}] <= bus.tile_in[r][c];
                end
            end
        end
    end

    assign bus.in_ready   = (r_state == COLLECT);
    assign bus.out_valid  = (r_state == FULL);
    assign bus.C          = r_c;
    assign bus.out_m_bit1 = r_m_bit1;
    assign bus.out_m_bit2 = r_m_bit2;
    assign bus.out_flag   = r_flag;
    assign bus.dup_err    = r_dup_err;
    assign bus.fmt_err    = r_fmt_err;
    assign bus.tile_mask  = r_tile_mask;

endmodule
`default_nettype wire

// File: tb/tb_matrix_tile_merge8.sv
`default_nettype none
// ============================================================================
//  tb_matrix_tile_merge8
//  Table-driven, directed and randomized checks against a behavioural model.
//  Revision: 1.0
// ============================================================================
module tb_matrix_tile_merge8;
    localparam int WIDTH = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clr   = 1'b0;

    matrix_tile_merge8_if #(.WIDTH(WIDTH)) bus ();

    matrix_tile_merge8 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model of the assembled matrix and its status
    logic [31:0] mc [8][8];
    logic [3:0]  mmask;
    logic        mfull, mdup, mfmt, mfl;
    logic [4:0]  mb1, mb2;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        bit       v;
        bit [1:0] idx;
        bit       ordy;
        bit       exp_ov;
        bit [3:0] exp_mask;
        bit       exp_ir;
    } vec_t;
    vec_t tbl [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                mc[r][c] = '0;
        mmask = 4'h0; mfull = 0; mdup = 0; mfmt = 0;
        mb1 = 5'd0; mb2 = 5'd0; mfl = 0;
    endtask

    // Applies the effect of one rising edge given the inputs currently driven
    task automatic model_edge();
        int k;
        if (clr) begin
            mmask = 4'h0; mdup = 0; mfmt = 0; mfull = 0;
        end else if (mfull) begin
            if (bus.out_ready) begin
                mmask = 4'h0; mdup = 0; mfmt = 0; mfull = 0;
            end
        end else if (bus.in_valid) begin
            k = int'(bus.tile_idx);
            if (mmask == 4'h0) begin
                mb1 = bus.m_bit1; mb2 = bus.m_bit2; mfl = bus.flag;
            end else if (bus.m_bit1 != mb1 || bus.m_bit2 != mb2 || bus.flag != mfl) begin
                mfmt = 1;
            end
            if (mmask[k]) mdup = 1;
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    mc[4*(k/2)+r][4*(k%2)+c] = bus.tile_in[r][c];
            mmask[k] = 1'b1;
            if (mmask == 4'hF) mfull = 1;
        end
    endtask

    task automatic compare_all();
        int bad_r, bad_c;
        bit bad;
        chk("out_valid",  32'(bus.out_valid),  32'(mfull));
        chk("in_ready",   32'(bus.in_ready),   32'(!mfull));
        chk("tile_mask",  32'(bus.tile_mask),  32'(mmask));
        chk("dup_err",    32'(bus.dup_err),    32'(mdup));
        chk("fmt_err",    32'(bus.fmt_err),    32'(mfmt));
        chk("out_m_bit1", 32'(bus.out_m_bit1), 32'(mb1));
        chk("out_m_bit2", 32'(bus.out_m_bit2), 32'(mb2));
        chk("out_flag",   32'(bus.out_flag),   32'(mfl));
        bad = 0; bad_r = 0; bad_c = 0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                if (!bad && bus.C[r][c] !== mc[r][c]) begin
                    bad = 1; bad_r = r; bad_c = c;
                end
        chk($sformatf("C[%0d][%0d]", bad_r, bad_c), bus.C[bad_r][bad_c], mc[bad_r][bad_c]);
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic fill_pattern(input int k);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                bus.tile_in[r][c] = 32'(32'h0100 * k + 4 * r + c);
    endtask

    task automatic fill_const(input logic [31:0] v);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                bus.tile_in[r][c] = v;
    endtask

    task automatic fill_rand();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                bus.tile_in[r][c] = $urandom;
    endtask

    task automatic offer(input int idx);
        bus.in_valid = 1'b1;
        bus.tile_idx = 2'(idx);
        cycle();
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int order [4];
        bit ok;

        tbl[0] = '{1'b1, 2'd0, 1'b1, 1'b0, 4'b0001, 1'b1};
        tbl[1] = '{1'b1, 2'd1, 1'b1, 1'b0, 4'b0011, 1'b1};
        tbl[2] = '{1'b1, 2'd2, 1'b1, 1'b0, 4'b0111, 1'b1};
        tbl[3] = '{1'b1, 2'd3, 1'b1, 1'b1, 4'b1111, 1'b0};
        tbl[4] = '{1'b0, 2'd0, 1'b1, 1'b0, 4'b0000, 1'b1};

        bus.in_valid = 0; bus.tile_idx = 0; bus.out_ready = 0;
        bus.m_bit1 = 0; bus.m_bit2 = 0; bus.flag = 0;
        fill_const(32'h0);
        model_reset();
        #23 rst_n = 1'b1;
        cycle();

        // Consecutive tiles 0..3 with out_ready high
        for (int i = 0; i < 5; i++) begin
            bus.in_valid  = tbl[i].v;
            bus.tile_idx  = tbl[i].idx;
            bus.out_ready = tbl[i].ordy;
            fill_pattern(int'(tbl[i].idx));
            cycle();
            chk($sformatf("t1_ov[%0d]", i),   32'(bus.out_valid), 32'(tbl[i].exp_ov));
            chk($sformatf("t1_mask[%0d]", i), 32'(bus.tile_mask), 32'(tbl[i].exp_mask));
            chk($sformatf("t1_ir[%0d]", i),   32'(bus.in_ready),  32'(tbl[i].exp_ir));
            if (i == 3) chk("t1_c56", bus.C[5][6], 32'h00000306);
        end
        bus.in_valid = 0;

        // Out-of-order with gaps, then backpressure with a tile offered during FULL
        bus.out_ready = 0;
        order = '{3, 0, 2, 1};
        for (int i = 0; i < 4; i++) begin
            fill_rand();
            offer(order[i]);
            if (i < 3) idle(2);
        end
        chk("t2_ov", 32'(bus.out_valid), 32'd1);
        bus.in_valid = 1; bus.tile_idx = 0;
        fill_const(32'hDEADBEEF);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t2_hold_mask", 32'(bus.tile_mask), 32'hF);
            chk("t2_hold_ir",   32'(bus.in_ready),  32'd0);
        end
        bus.in_valid = 0; bus.out_ready = 1;
        cycle();
        chk("t2_done_ov", 32'(bus.out_valid), 32'd0);

        // Duplicate tile 1: last write wins, dup_err until handshake
        bus.out_ready = 0;
        fill_const(32'hAAAAAAAA); offer(1);
        fill_const(32'h55555555); offer(1);
        fill_rand(); offer(0);
        fill_rand(); offer(2);
        fill_rand(); offer(3);
        chk("t3_dup", 32'(bus.dup_err), 32'd1);
        ok = 1;
        for (int r = 0; r < 4; r++)
            for (int c = 4; c < 8; c++)
                if (bus.C[r][c] !== 32'h55555555) ok = 0;
        chk("t3_tile1_55", 32'(ok), 32'd1);
        bus.out_ready = 1;
        cycle();
        chk("t3_dup_clr", 32'(bus.dup_err), 32'd0);

        // Format mismatch on a later tile
        bus.out_ready = 0;
        bus.m_bit1 = 5'd10; bus.m_bit2 = 5'd3; bus.flag = 1;
        fill_rand(); offer(0);
        bus.m_bit1 = 5'd11;
        fill_rand(); offer(2);
        bus.m_bit1 = 5'd10;
        fill_rand(); offer(1);
        fill_rand(); offer(3);
        chk("t4_mb1", 32'(bus.out_m_bit1), 32'd10);
        chk("t4_fmt", 32'(bus.fmt_err),    32'd1);
        bus.out_ready = 1;
        cycle();
        chk("t4_fmt_clr", 32'(bus.fmt_err), 32'd0);

        // clr together with the third tile's accept
        bus.out_ready = 0;
        fill_rand(); offer(0);
        fill_rand(); offer(1);
        fill_rand();
        clr = 1; bus.in_valid = 1; bus.tile_idx = 2;
        cycle();
        clr = 0; bus.in_valid = 0;
        chk("t5_mask", 32'(bus.tile_mask), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t5_no_ov", 32'(bus.out_valid), 32'd0);
        end
        for (int k = 0; k < 4; k++) begin
            fill_rand(); offer(k);
        end
        chk("t5_fresh_ov", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1;
        cycle();

        // Asynchronous reset while FULL
        bus.out_ready = 0;
        for (int k = 0; k < 4; k++) begin
            fill_rand(); offer(k);
        end
        chk("t6_full", 32'(bus.out_valid), 32'd1);
        model_edge();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        chk("t6_rst_ov",   32'(bus.out_valid), 32'd0);
        chk("t6_rst_mask", 32'(bus.tile_mask), 32'd0);
        compare_all();
        #3 rst_n = 1'b1;
        cycle();
        chk("t6_ir", 32'(bus.in_ready), 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            clr           = ($urandom_range(0, 19) == 0);
            bus.in_valid  = $urandom_range(0, 1);
            bus.tile_idx  = 2'($urandom_range(0, 3));
            bus.out_ready = $urandom_range(0, 1);
            bus.m_bit1    = ($urandom_range(0, 7) == 0) ? 5'd8 : 5'd7;
            bus.m_bit2    = 5'd3;
            bus.flag      = ($urandom_range(0, 15) == 0);
            fill_rand();
            cycle();
        end
        clr = 0; bus.in_valid = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/matrix_tile_merge8.md
Name: matrix_tile_merge8

Overview:
- Reassembles an 8x8 result matrix from four 4x4 tiles that arrive one at a time, each tagged with a tile index.
- Sits downstream of a single time-shared matrix_addN 4x4 engine. It is the collecting end of the 8x8 -> 4x4 tile decomposition.
- Buffers the tiles, tracks which tiles have arrived, carries the arithmetic format fields, and presents the full matrix on a valid/ready output handshake.

Parameters:
width, 16, half element width; every matrix element is 2*width bits.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous flush of the partial or pending matrix
in_valid  input  1  tile present on tile_in
in_ready  output  1  block can accept a tile
tile_idx  input  2  tile position: 0 = rows0-3/cols0-3, 1 = rows0-3/cols4-7, 2 = rows4-7/cols0-3, 3 = rows4-7/cols4-7
tile_in  input  [2*width-1:0] x [3:0][3:0]  4x4 tile, [row][col]
m_bit1  input  5  format field accompanying the tile
m_bit2  input  5  format field accompanying the tile
flag  input  1  format flag accompanying the tile
out_valid  output  1  full 8x8 matrix available
out_ready  input  1  consumer takes the matrix
C  output  [2*width-1:0] x [7:0][7:0]  assembled matrix, [row][col]
out_m_bit1  output  5  format latched from the first tile of the matrix
out_m_bit2  output  5  format latched from the first tile of the matrix
out_flag  output  1  format latched from the first tile of the matrix
dup_err  output  1  a tile index was received twice for this matrix
fmt_err  output  1  a tile's format differed from the latched format
tile_mask  output  4  bit i set once tile i has been received

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = COLLECT; tile_mask = 0; out_valid = 0; dup_err = 0; fmt_err = 0.
  - C, out_m_bit1, out_m_bit2, out_flag = 0.
  - in_ready = 1 from the first edge after release.
  - A reset mid-collection or mid-output discards all data.
- States: COLLECT, FULL.
- in_ready = (state == COLLECT). A tile is accepted when in_valid && in_ready at a rising edge.
- Tile placement on accept: tile_in[r][c] is written to C[R0+r][C0+c], where R0 = 4*tile_idx[1] and C0 = 4*tile_idx[0]. tile_mask[tile_idx] is set.
- First tile of a matrix (tile_mask == 0 before the accept): latches m_bit1, m_bit2, flag into the out_* fields.
- Later tiles: if any format field differs from the latched value, fmt_err is set (sticky for this matrix). The tile data is still stored.
- Duplicate tile (tile_mask[tile_idx] already set):
  - Data overwrites the earlier tile (last write wins).
  - dup_err is set (sticky).
  - tile_mask is unchanged.
- COLLECT -> FULL on the edge where the accept makes tile_mask == 4'b1111. From that edge:
  - out_valid = 1 and in_ready = 0.
  - Latency from the final tile accept to out_valid is 1 edge.
- FULL:
  - C, out_* fields, dup_err, fmt_err and tile_mask are held stable until the handshake.
  - On out_valid && out_ready: the next state is COLLECT, with tile_mask, dup_err and fmt_err cleared, out_valid = 0 and in_ready = 1 on the following cycle.
  - C keeps its old contents until overwritten.
  - No same-cycle input acceptance while in FULL. Best-case throughput is one matrix per 5 cycles.
- clr (synchronous, highest priority after reset):
  - Returns to COLLECT and clears tile_mask, dup_err, fmt_err and out_valid.
  - A tile offered in the same cycle is dropped.
  - In FULL, clr drops the pending matrix even if out_ready = 1 in that cycle (no transfer counted).
- Tiles may arrive in any order, with any number of idle cycles between them.
- Element values are stored verbatim; no arithmetic or width change.

Test Plan:
- Reset, then tiles 0,1,2,3 on consecutive cycles, tile k filled with value 16'h0100*k + 4*r + c, out_ready = 1:
  - out_valid rises 1 edge after tile 3 is accepted.
  - C[5][6] = 32'h00000306 (tile 3, r=1, c=2).
  - Matrix transfers; in_ready = 1 on the next cycle.
- Tiles in order 3,0,2,1 with 2 idle cycles between each, out_ready held 0 for 5 cycles:
  - out_valid stays 1 and C stays stable; in_ready stays 0.
  - in_valid asserted during FULL is not accepted (tile_mask stays 4'hF).
- Tile 1 sent twice, first all-0xAA then all-0x55, followed by tiles 0,2,3:
  - C rows0-3/cols4-7 = 0x55.
  - dup_err = 1, and it clears after the output handshake.
- Tile 0 with m_bit1=5'd10, flag=1, then tile 2 with m_bit1=5'd11:
  - out_m_bit1 = 10; fmt_err = 1 when the matrix completes.
- clr in the same cycle as the accept of the 3rd tile:
  - tile_mask = 0 next cycle; out_valid never rises.
  - A fresh 4-tile sequence then completes normally.
- rst_n pulled low asynchronously mid-cycle in FULL:
  - out_valid, tile_mask, C and the error flags go to 0 immediately, without waiting for a clock edge.
  - in_ready = 1 after release.
